// File: rtl/msi001_cfg_pkg.sv
// Shared types and constants for the MSI001 configuration sequencer.
// Default register table, alternate tuning word and FSM encoding.
package msi001_cfg_pkg;

  localparam int MSI001_WORD_W = 24;

  localparam logic [MSI001_WORD_W-1:0] MSI001_CFG_W0  = 24'hEBAEAB;
  localparam logic [MSI001_WORD_W-1:0] MSI001_CFG_W1  = 24'hEBAEAB;
  localparam logic [MSI001_WORD_W-1:0] MSI001_CFG_W2  = 24'hEBAEAB;
  localparam logic [MSI001_WORD_W-1:0] MSI001_CFG_ALT = 24'h09AFAB;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_GO   = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_GO   = ST_GO,
    S_WAIT = ST_WAIT,
    S_GAP  = ST_GAP,
    S_FIN  = ST_FIN
  } state_e;

  function automatic logic [MSI001_WORD_W-1:0] msi001_default(
    input logic [3:0] idx
  );
    case (idx)
      4'd0:    return MSI001_CFG_W0;
      4'd1:    return MSI001_CFG_W1;
      4'd2:    return MSI001_CFG_W2;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/msi001_cfg_if.sv
// Word handshake between the sequencer (master) and the SPI
// serializer (slave).
interface msi001_cfg_if;
  import msi001_cfg_pkg::*;

  logic [MSI001_WORD_W-1:0] spi_data;
  logic                     spi_go;
  logic                     spi_complete;

  modport master (
    output spi_data,
    output spi_go,
    input  spi_complete
  );

  modport slave (
    input  spi_data,
    input  spi_go,
    output spi_complete
  );

endinterface

// File: rtl/msi001_cfg_table.sv
// Register word table: constant ROM by default, writable array when
// MSI001_CFG_WR_EN is defined.
module msi001_cfg_table
  import msi001_cfg_pkg::*;
#(
  parameter int NUM_WORDS = 3
) (
`ifdef MSI001_CFG_WR_EN
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_wr_i,
  input  logic [3:0]               cfg_addr_i,
  input  logic [MSI001_WORD_W-1:0] cfg_wdata_i,
`endif
  input  logic [3:0]               idx_i,
  output logic [MSI001_WORD_W-1:0] word_o
);

  logic                     hit;
  logic [MSI001_WORD_W-1:0] rd;

  assign hit    = int'(idx_i) < NUM_WORDS;
  assign word_o = hit ? rd : '0;

`ifdef MSI001_CFG_WR_EN
  logic [MSI001_WORD_W-1:0] tbl_q [NUM_WORDS];

  // Out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++)
        tbl_q[i] <= msi001_default(4'(i));
    end else if (cfg_wr_i) begin
      for (int i = 0; i < NUM_WORDS; i++)
        if (cfg_addr_i == 4'(i))
          tbl_q[i] <= cfg_wdata_i;
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      if (idx_i == 4'(i))
        rd = tbl_q[i];
  end
`else
  assign rd = msi001_default(idx_i);
`endif

endmodule

// File: rtl/msi001_cfg_sequencer.sv
// Walks the register table and feeds one word per go strobe to the
// MSI001 serializer. Optional write port: MSI001_CFG_WR_EN.
module msi001_cfg_sequencer
  import msi001_cfg_pkg::*;
#(
  parameter int NUM_WORDS   = 3,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [3:0]               word_idx,
`ifdef MSI001_CFG_WR_EN
  input  logic                     cfg_wr,
  input  logic [3:0]               cfg_addr,
  input  logic [MSI001_WORD_W-1:0] cfg_wdata,
`endif
  msi001_cfg_if.master             spi
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_WORDS - 1);

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic [MSI001_WORD_W-1:0] data_q, data_d;
  logic [TW-1:0]            to_q, to_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic                     go_q, go_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic [MSI001_WORD_W-1:0] tbl_word;

  msi001_cfg_table #(
    .NUM_WORDS (NUM_WORDS)
  ) u_tbl (
`ifdef MSI001_CFG_WR_EN
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_wr_i    (cfg_wr),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
`endif
    .idx_i       (idx_q),
    .word_o      (tbl_word)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    to_d    = to_q;
    gap_d   = gap_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        data_d  = tbl_word;
        state_d = S_GO;
      end
      S_GO: begin
        to_d    = '0;
        state_d = S_WAIT;
      end
      // Completion is checked first so it wins over a same-cycle timeout.
      S_WAIT: begin
        if (spi.spi_complete) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_FIN;
          end else if (GAP_CYC == 0) begin
            state_d = S_LOAD;
            idx_d   = idx_q + 4'd1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_LOAD;
          idx_d   = idx_q + 4'd1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_FIN: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    go_d   = (state_d == S_GO);
    done_d = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      to_q    <= '0;
      gap_q   <= '0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      go_q    <= go_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = err_q;
  assign word_idx     = idx_q;
  assign spi.spi_data = data_q;
  assign spi.spi_go   = go_q;

endmodule

// File: tb/tb_msi001_cfg_sequencer.sv
// Randomized bench for msi001_cfg_sequencer: two instances (gap 8 and
// gap 0) checked against a cycle-stamped schedule model.
module tb_msi001_cfg_sequencer;
  import msi001_cfg_pkg::*;

  localparam int NW  = 3;
  localparam int TO  = 64;
  localparam int INF = 2147483647;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_r [2];
  logic       start_r [2];
  logic       cpl_r [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       err_w [2];
  logic [3:0] idx_w [2];
`ifdef MSI001_CFG_WR_EN
  logic        wr_r [2];
  logic [3:0]  addr_r [2];
  logic [23:0] wdat_r [2];
`endif

  msi001_cfg_if if0 ();
  msi001_cfg_if if1 ();
  assign if0.spi_complete = cpl_r[0];
  assign if1.spi_complete = cpl_r[1];

  msi001_cfg_sequencer #(
    .NUM_WORDS(NW), .GAP_CYC(8), .TIMEOUT_CYC(TO)
  ) u_dut0 (
    .clk(clk), .rst(rst_r[0]), .start(start_r[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .timeout_err(err_w[0]), .word_idx(idx_w[0]),
`ifdef MSI001_CFG_WR_EN
    .cfg_wr(wr_r[0]), .cfg_addr(addr_r[0]), .cfg_wdata(wdat_r[0]),
`endif
    .spi(if0)
  );

  msi001_cfg_sequencer #(
    .NUM_WORDS(NW), .GAP_CYC(0), .TIMEOUT_CYC(TO)
  ) u_dut1 (
    .clk(clk), .rst(rst_r[1]), .start(start_r[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .timeout_err(err_w[1]), .word_idx(idx_w[1]),
`ifdef MSI001_CFG_WR_EN
    .cfg_wr(wr_r[1]), .cfg_addr(addr_r[1]), .cfg_wdata(wdat_r[1]),
`endif
    .spi(if1)
  );

  int n_chk = 0;
  int n_err = 0;
  int t = 0;

  int gap [2];
  int go_at [2], cpl_at [2], done_at [2], err_at [2];
  int acc_at [2], rst_at [2], busy_from [2], busy_end [2];
  int w_lo [2], w_hi [2], k [2], runs [2];
  int rst_plan [2], start_plan [2], spur_plan [2], wr_plan [2];
  logic        exp_err [2];
  logic [23:0] exp_data [2];
  logic [23:0] tbl [2][3];

  task automatic chk_eq(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h want %0h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  function automatic logic [23:0] obs_data(input int i);
    return (i == 0) ? if0.spi_data : if1.spi_data;
  endfunction

  function automatic logic obs_go(input int i);
    return (i == 0) ? if0.spi_go : if1.spi_go;
  endfunction

  // Model state after an rst edge at the end of cycle t.
  task automatic mdl_reset(input int i);
    rst_at[i] = t + 1;
    busy_from[i] = 1; busy_end[i] = 0;
    go_at[i] = -1; cpl_at[i] = -1; done_at[i] = -1;
    err_at[i] = -1; acc_at[i] = -1;
    w_lo[i] = -1; w_hi[i] = -1; k[i] = 0;
    rst_plan[i] = -1; spur_plan[i] = -1; start_plan[i] = -1;
    for (int j = 0; j < NW; j++) tbl[i][j] = 24'hEBAEAB;
  endtask

  task automatic step(input int i);
    logic busy_e;
    int lat, c, r;
`ifdef MSI001_CFG_WR_EN
    int a;
    logic [23:0] d;
`endif
    if (t == rst_at[i]) begin
      exp_err[i] = 1'b0;
      exp_data[i] = '0;
      chk_eq($sformatf("rst_idx%0d", i), 32'(idx_w[i]), 0);
    end
    if (t == acc_at[i]) exp_err[i] = 1'b0;
    if (t == err_at[i]) exp_err[i] = 1'b1;
    if (t == go_at[i]) exp_data[i] = tbl[i][k[i]];
    busy_e = (t >= busy_from[i]) && (t <= busy_end[i]);

    chk_eq($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(busy_e));
    chk_eq($sformatf("done%0d", i), 32'(done_w[i]), 32'(t == done_at[i]));
    chk_eq($sformatf("go%0d", i), 32'(obs_go(i)), 32'(t == go_at[i]));
    chk_eq($sformatf("err%0d", i), 32'(err_w[i]), 32'(exp_err[i]));
    chk_eq($sformatf("data%0d", i), 32'(obs_data(i)), 32'(exp_data[i]));

    if (t == go_at[i]) begin
      chk_eq($sformatf("go_idx%0d", i), 32'(idx_w[i]), k[i]);
`ifdef MSI001_CFG_WR_EN
      if (runs[i] == 1 && k[i] == 2)
        chk_eq($sformatf("wr_w2_%0d", i), 32'(obs_data(i)), 32'h09AFAB);
      if (runs[i] == 1 && k[i] == 0) wr_plan[i] = t + 5;
`endif
      case (runs[i])
        1, 4: lat = 50;
        2: lat = -1;
        3: lat = TO;
        default: begin
          r = int'($urandom % 16);
          if (r < 9) lat = 50;
          else if (r < 12) lat = 1 + int'($urandom % 63);
          else if (r == 12) lat = TO;
          else if (r == 13) lat = TO + 1;
          else lat = -1;
        end
      endcase
      if (runs[i] == 1 && k[i] == 0) start_plan[i] = t + 5;
      if (runs[i] == 4 && k[i] == 1) rst_plan[i] = t + 10;
      w_lo[i] = t + 1;
      if (lat > 0 && lat <= TO) begin
        c = t + lat;
        cpl_at[i] = c;
        w_hi[i] = c;
        if (runs[i] == 1) spur_plan[i] = c + 2;
        if (k[i] < NW - 1) begin
          go_at[i] = c + gap[i] + 2;
          k[i]++;
        end else begin
          go_at[i] = -1;
          done_at[i] = c + 1;
          busy_end[i] = c + 1;
        end
      end else begin
        cpl_at[i] = (lat > 0) ? t + lat : -1;
        w_hi[i] = t + TO;
        go_at[i] = -1;
        err_at[i] = t + TO + 1;
        busy_end[i] = t + TO;
      end
    end

    rst_r[i] = 1'b0;
    start_r[i] = 1'b0;
    cpl_r[i] = 1'b0;
    if (t == rst_plan[i] || (busy_e && $urandom % 2000 == 0)) begin
      rst_r[i] = 1'b1;
      start_r[i] = ($urandom % 2) == 1;
      mdl_reset(i);
    end else begin
      if (!busy_e) begin
        if ($urandom % 20 == 0) begin
          start_r[i] = 1'b1;
          acc_at[i] = t + 1;
          busy_from[i] = t + 1;
          busy_end[i] = INF;
          go_at[i] = t + 2;
          k[i] = 0;
          runs[i]++;
        end
      end else if (t == start_plan[i] || $urandom % 200 == 0) begin
        start_r[i] = 1'b1;
      end
      if (t == cpl_at[i]) cpl_r[i] = 1'b1;
      else if (!(t >= w_lo[i] && t <= w_hi[i]) &&
               (t == spur_plan[i] || $urandom % 30 == 0))
        cpl_r[i] = 1'b1;
    end

`ifdef MSI001_CFG_WR_EN
    wr_r[i] = 1'b0;
    if (!rst_r[i] && t != go_at[i] - 1) begin
      a = -1;
      d = '0;
      if (t == wr_plan[i]) begin
        a = 2; d = 24'h09AFAB;
      end else if (t == wr_plan[i] + 1) begin
        a = 5; d = 24'($urandom);
      end else if (runs[i] > 1 && $urandom % 50 == 0) begin
        a = int'($urandom % 8); d = 24'($urandom);
      end
      if (a >= 0) begin
        wr_r[i] = 1'b1;
        addr_r[i] = 4'(a);
        wdat_r[i] = d;
        if (a < NW) tbl[i][a] = d;
      end
    end
`endif
  endtask

  initial begin
    gap[0] = 8;
    gap[1] = 0;
    for (int i = 0; i < 2; i++) begin
      rst_r[i] = 1'b1;
      start_r[i] = 1'b0;
      cpl_r[i] = 1'b0;
      runs[i] = 0;
      wr_plan[i] = -10;
      exp_err[i] = 1'b0;
      exp_data[i] = '0;
`ifdef MSI001_CFG_WR_EN
      wr_r[i] = 1'b0;
      addr_r[i] = '0;
      wdat_r[i] = '0;
`endif
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      mdl_reset(i);
      rst_at[i] = t;
    end
    repeat (14000) begin
      step(0);
      step(1);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
